// File: rtl/cia_pkg.sv
// Shared types and constants for the CIA bus sequencer and its E-clock generator.
package cia_pkg;
    localparam int CIA_ECLK_DIV  = 10;
    localparam int CIA_ECLK_HIGH = 4;
    localparam logic [7:0] CIA_OPEN_BUS = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STROBE,
        ST_ACK,
        ST_DONE
    } cia_state_t;
endpackage

// File: rtl/cia_bus_sequencer_if.sv
// CPU-side access handshake into the CIA bus sequencer.
interface cia_bus_sequencer_if;
    logic        req;
    logic        we;
    logic        sel_a;
    logic        sel_b;
    logic [3:0]  rs;
    logic [7:0]  wdata;
    logic [15:0] rdata;
    logic        ack;

    modport master (output req, we, sel_a, sel_b, rs, wdata, input rdata, ack);
    modport slave  (input req, we, sel_a, sel_b, rs, wdata, output rdata, ack);
endinterface

// File: rtl/cia_eclk_gen.sv
// Free-running E-clock divider: ecnt counts 0..ECLK_DIV-1 on clk7_en, E high for the last ECLK_HIGH counts.
module cia_eclk_gen #(
    parameter int ECLK_DIV  = 10,
    parameter int ECLK_HIGH = 4,
    localparam int CW = (ECLK_DIV > 1) ? $clog2(ECLK_DIV) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clk7_en,
    output logic [CW-1:0] o_ecnt,
    output logic          o_eclk,
    output logic          o_eclk_pulse
);
    logic [CW-1:0] r_ecnt;
    logic [CW-1:0] w_ecnt_nxt;
    logic          r_eclk;
    logic          r_eclk_pulse;

    assign w_ecnt_nxt = (r_ecnt == CW'(ECLK_DIV - 1)) ? '0 : r_ecnt + CW'(1);

    // E level and pulse are registered from the next count so they stay aligned with ecnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ecnt       <= '0;
            r_eclk       <= 1'b0;
            r_eclk_pulse <= 1'b0;
        end else if (i_clk7_en) begin
            r_ecnt       <= w_ecnt_nxt;
            r_eclk       <= (w_ecnt_nxt >= CW'(ECLK_DIV - ECLK_HIGH));
            r_eclk_pulse <= (w_ecnt_nxt == CW'(ECLK_DIV - 1));
        end
    end

    assign o_ecnt       = r_ecnt;
    assign o_eclk       = r_eclk;
    assign o_eclk_pulse = r_eclk_pulse;
endmodule

// File: rtl/cia_bus_sequencer.sv
// Holds CPU CIA accesses until the E-clock strobe slot, issues one-period strobes, latches read data, acks.
module cia_bus_sequencer
    import cia_pkg::*;
#(
    parameter int ECLK_DIV  = CIA_ECLK_DIV,
    parameter int ECLK_HIGH = CIA_ECLK_HIGH,
    localparam int CW = (ECLK_DIV > 1) ? $clog2(ECLK_DIV) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clk7_en,
    cia_bus_sequencer_if.slave   bus,
    input  logic [7:0]           i_cia_a_dout,
    input  logic [7:0]           i_cia_b_dout,
    output logic                 o_eclk,
    output logic                 o_eclk_pulse,
    output logic                 o_cia_a_aen,
    output logic                 o_cia_b_aen,
    output logic                 o_cia_rd,
    output logic                 o_cia_wr,
    output logic [3:0]           o_cia_rs,
    output logic [7:0]           o_cia_din
);
    logic [CW-1:0] w_ecnt;
    cia_state_t    r_state, w_state_nxt;

    logic        r_we, r_sel_a, r_sel_b;
    logic        r_aen_a, r_aen_b, r_rd, r_wr, r_ack;
    logic [3:0]  r_cia_rs;
    logic [7:0]  r_cia_din;
    logic [15:0] r_rdata;

    logic w_capture, w_aen_a, w_aen_b, w_rd, w_wr, w_ack;

    cia_eclk_gen #(.ECLK_DIV(ECLK_DIV), .ECLK_HIGH(ECLK_HIGH)) u_eclk (
        .clk          (clk),
        .reset        (reset),
        .i_clk7_en    (i_clk7_en),
        .o_ecnt       (w_ecnt),
        .o_eclk       (o_eclk),
        .o_eclk_pulse (o_eclk_pulse)
    );

    // Outputs are computed for the coming period and registered, so STROBE sees them for exactly one period.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_aen_a     = 1'b0;
        w_aen_b     = 1'b0;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req && (w_ecnt <= CW'(ECLK_DIV - ECLK_HIGH - 1))) begin
                    w_capture = 1'b1;
                    // With a very short high phase the capture slot can already be the pre-strobe count.
                    if (w_ecnt == CW'(ECLK_DIV - 2)) begin
                        w_state_nxt = ST_STROBE;
                        w_aen_a     = bus.sel_a;
                        w_aen_b     = bus.sel_b;
                        w_rd        = !bus.we && (bus.sel_a || bus.sel_b);
                        w_wr        =  bus.we && (bus.sel_a || bus.sel_b);
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (w_ecnt == CW'(ECLK_DIV - 2)) begin
                    w_state_nxt = ST_STROBE;
                    w_aen_a     = r_sel_a;
                    w_aen_b     = r_sel_b;
                    w_rd        = !r_we && (r_sel_a || r_sel_b);
                    w_wr        =  r_we && (r_sel_a || r_sel_b);
                end
            end
            ST_STROBE: begin
                w_state_nxt = ST_ACK;
                w_ack       = 1'b1;
            end
            ST_ACK:  w_state_nxt = ST_DONE;
            ST_DONE: if (!bus.req) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_sel_a   <= 1'b0;
            r_sel_b   <= 1'b0;
            r_aen_a   <= 1'b0;
            r_aen_b   <= 1'b0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_ack     <= 1'b0;
            r_cia_rs  <= '0;
            r_cia_din <= '0;
            r_rdata   <= {CIA_OPEN_BUS, CIA_OPEN_BUS};
        end else if (i_clk7_en) begin
            r_state <= w_state_nxt;
            r_aen_a <= w_aen_a;
            r_aen_b <= w_aen_b;
            r_rd    <= w_rd;
            r_wr    <= w_wr;
            r_ack   <= w_ack;
            if (w_capture) begin
                r_we      <= bus.we;
                r_sel_a   <= bus.sel_a;
                r_sel_b   <= bus.sel_b;
                r_cia_rs  <= bus.rs;
                r_cia_din <= bus.wdata;
            end
            // Read data is taken on the same edge the CIA samples the strobe; unselected bytes float high.
            if (r_state == ST_STROBE && !r_we) begin
                r_rdata <= {r_sel_b ? i_cia_b_dout : CIA_OPEN_BUS,
                            r_sel_a ? i_cia_a_dout : CIA_OPEN_BUS};
            end
        end
    end

    assign o_cia_a_aen = r_aen_a;
    assign o_cia_b_aen = r_aen_b;
    assign o_cia_rd    = r_rd;
    assign o_cia_wr    = r_wr;
    assign o_cia_rs    = r_cia_rs;
    assign o_cia_din   = r_cia_din;
    assign bus.rdata   = r_rdata;
    assign bus.ack     = r_ack;
endmodule

// File: tb/tb_cia_bus_sequencer.sv
// Directed bench for cia_bus_sequencer: E-clock shape, access vectors, held request, reset in STROBE.
module tb_cia_bus_sequencer;
    import cia_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk7_en;
    logic [7:0] a_dout, b_dout;
    logic       eclk, eclk_pulse, a_aen, b_aen, cia_rd, cia_wr;
    logic [3:0] cia_rs;
    logic [7:0] cia_din;

    cia_bus_sequencer_if bus_if ();

    cia_bus_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .i_clk7_en    (clk7_en),
        .bus          (bus_if),
        .i_cia_a_dout (a_dout),
        .i_cia_b_dout (b_dout),
        .o_eclk       (eclk),
        .o_eclk_pulse (eclk_pulse),
        .o_cia_a_aen  (a_aen),
        .o_cia_b_aen  (b_aen),
        .o_cia_rd     (cia_rd),
        .o_cia_wr     (cia_wr),
        .o_cia_rs     (cia_rs),
        .o_cia_din    (cia_din)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int m_ecnt = 0;

    typedef struct {
        logic        we, sa, sb;
        logic [3:0]  rs;
        logic [7:0]  wd, ad, bd;
        int          start;
        int          lat;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (ecnt=%0d)", name, act, exp, m_ecnt);
        end
    endtask

    // One clk7_en period: two idle clocks then one enabled edge; sample #1 after it.
    task automatic tick();
        clk7_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 clk7_en = 1'b1;
        @(posedge clk);
        #1 clk7_en = 1'b0;
        m_ecnt = reset ? 0 : (m_ecnt + 1) % 10;
    endtask

    task automatic run_vec(input vec_t v);
        int lat, nstb;
        while (m_ecnt != v.start) tick();
        bus_if.we = v.we; bus_if.sel_a = v.sa; bus_if.sel_b = v.sb;
        bus_if.rs = v.rs; bus_if.wdata = v.wd; a_dout = v.ad; b_dout = v.bd;
        bus_if.req = 1'b1;
        lat = -1; nstb = 0;
        for (int i = 1; i <= 30 && lat < 0; i++) begin
            tick();
            if (cia_rd || cia_wr || a_aen || b_aen) begin
                nstb++;
                chk("strobe_ecnt", m_ecnt, 9);
                chk("strobe_pulse", eclk_pulse, 1'b1);
                chk("aen_a", a_aen, v.sa);
                chk("aen_b", b_aen, v.sb);
                chk("rd", cia_rd, !v.we);
                chk("wr", cia_wr, v.we);
                chk("cia_rs", cia_rs, v.rs);
                chk("cia_din", cia_din, v.wd);
            end
            if (bus_if.ack) begin
                lat = i;
                chk("rdata", bus_if.rdata, v.rdata);
                chk("ack_eclk", eclk, 1'b0);
                chk("ack_ecnt", m_ecnt, 0);
            end
        end
        chk("latency", lat, v.lat);
        chk("strobe_count", nstb, (v.sa || v.sb) ? 1 : 0);
    endtask

    initial begin
        int first_rise, nstb, nack;
        bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.sel_a = 1'b0; bus_if.sel_b = 1'b0;
        bus_if.rs = '0; bus_if.wdata = '0; a_dout = '0; b_dout = '0;
        clk7_en = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        chk("rst_eclk", eclk, 1'b0);
        chk("rst_pulse", eclk_pulse, 1'b0);
        chk("rst_strobes", {a_aen, b_aen, cia_rd, cia_wr}, 4'h0);
        chk("rst_ack", bus_if.ack, 1'b0);
        chk("rst_rdata", bus_if.rdata, 16'hFFFF);
        chk("rst_rs_din", {cia_rs, cia_din}, 12'h000);

        first_rise = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk("eclk", eclk, (m_ecnt >= 6));
            chk("eclk_pulse", eclk_pulse, (m_ecnt == 9));
            if (eclk && first_rise < 0) first_rise = i;
        end
        chk("first_rise", first_rise, 6);

        vecs[0] = '{1'b1, 1'b0, 1'b1, 4'h1, 8'h5A, 8'h00, 8'h00, 2, 8,  16'hFFFF};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 4'h3, 8'h00, 8'h12, 8'h34, 0, 10, 16'h3412};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4'hD, 8'h11, 8'hC3, 8'h55, 6, 14, 16'hFFC3};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 4'hF, 8'hA5, 8'h66, 8'h77, 5, 5,  16'hFFC3};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 4'h4, 8'h00, 8'h21, 8'h43, 3, 7,  16'hFFFF};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 4'h7, 8'h00, 8'h88, 8'h77, 4, 6,  16'h77FF};
        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k]);
            bus_if.req = 1'b0;
            tick(); tick();
        end

        // Held request after ack must not start another access.
        run_vec('{1'b1, 1'b1, 1'b0, 4'h2, 8'h3C, 8'h00, 8'h00, 1, 9, 16'h77FF});
        nstb = 0; nack = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cia_rd || cia_wr || a_aen || b_aen) nstb++;
            if (bus_if.ack) nack++;
        end
        chk("held_strobes", nstb, 0);
        chk("held_acks", nack, 0);
        bus_if.req = 1'b0;
        tick(); tick();

        // Reset landing in the STROBE period of a read.
        while (m_ecnt != 0) tick();
        bus_if.we = 1'b0; bus_if.sel_a = 1'b1; bus_if.sel_b = 1'b0; a_dout = 8'h99;
        bus_if.req = 1'b1;
        for (int i = 0; i < 15 && m_ecnt != 9; i++) tick();
        chk("pre_rst_rd", cia_rd, 1'b1);
        reset = 1'b1; bus_if.req = 1'b0;
        tick();
        reset = 1'b0;
        chk("abort_strobes", {a_aen, b_aen, cia_rd, cia_wr}, 4'h0);
        chk("abort_ack", bus_if.ack, 1'b0);
        chk("abort_rdata", bus_if.rdata, 16'hFFFF);
        chk("abort_eclk", {eclk, eclk_pulse}, 2'b00);
        nack = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_if.ack) nack++;
            chk("post_rst_eclk", eclk, (m_ecnt >= 6));
        end
        chk("abort_no_ack", nack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
